// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encodings and bus-level constants for the I2C target
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_ADDR     = 3'b001,
        ST_ADDR_ACK = 3'b010,
        ST_RX_BYTE  = 3'b011,
        ST_RX_ACK   = 3'b100,
        ST_TX_BYTE  = 3'b101,
        ST_TX_ACK   = 3'b110
    } i2c_state_e;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_slave_controller_if.sv
// rtl/i2c_slave_controller_if.sv - user-side byte interface of the I2C target
interface i2c_slave_controller_if;

    logic [7:0] data_in;
    logic       rx_nack;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       tx_load;
    logic       master_nack_received;
    logic       addressed;
    logic       bus_busy;
    logic [2:0] i2c_state;

    modport slave (
        input  data_in, rx_nack,
        output data_out, rx_valid, tx_load, master_nack_received,
               addressed, bus_busy, i2c_state
    );

    modport master (
        output data_in, rx_nack,
        input  data_out, rx_valid, tx_load, master_nack_received,
               addressed, bus_busy, i2c_state
    );

endinterface

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - N-stage synchronizer with one history flop for edge detection
module i2c_line_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    // Preset high so an idle, pulled-up bus produces no spurious edge after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/i2c_slave_controller.sv
// rtl/i2c_slave_controller.sv - 7-bit address I2C target with byte-level user interface
module i2c_slave_controller
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    inout  wire                     i2c_sda,
    input  logic                    i2c_scl,
    i2c_slave_controller_if.slave   usr
);

    logic sda_lvl, sda_rise, sda_fall;
    logic scl_lvl, scl_rise, scl_fall;

    i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .clk(clk), .reset(reset), .din(i2c_sda),
        .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .clk(clk), .reset(reset), .din(i2c_scl),
        .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d, tx_q, tx_d, data_out_q, data_out_d;
    logic       sda_low_q, sda_low_d, ack_slot_q, ack_slot_d;
    logic       addressed_q, addressed_d, busy_q, busy_d;
    logic       rx_valid_q, rx_valid_d, tx_load_q, tx_load_d, mnack_q, mnack_d;

    wire start_cond = sda_fall & scl_lvl;
    wire stop_cond  = sda_rise & scl_lvl;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd7;
            shift_q     <= 8'h00;
            tx_q        <= 8'h00;
            data_out_q  <= 8'h00;
            sda_low_q   <= 1'b0;
            ack_slot_q  <= 1'b0;
            addressed_q <= 1'b0;
            busy_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_load_q   <= 1'b0;
            mnack_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            data_out_q  <= data_out_d;
            sda_low_q   <= sda_low_d;
            ack_slot_q  <= ack_slot_d;
            addressed_q <= addressed_d;
            busy_q      <= busy_d;
            rx_valid_q  <= rx_valid_d;
            tx_load_q   <= tx_load_d;
            mnack_q     <= mnack_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        data_out_d  = data_out_q;
        sda_low_d   = sda_low_q;
        ack_slot_d  = ack_slot_q;
        addressed_d = addressed_q;
        busy_d      = busy_q;
        rx_valid_d  = 1'b0;
        tx_load_d   = 1'b0;
        mnack_d     = 1'b0;

        if (start_cond) begin
            state_d     = ST_ADDR;
            cnt_d       = 3'd7;
            sda_low_d   = 1'b0;
            ack_slot_d  = 1'b0;
            addressed_d = 1'b0;
            busy_d      = 1'b1;
        end else if (stop_cond) begin
            state_d     = ST_IDLE;
            sda_low_d   = 1'b0;
            ack_slot_d  = 1'b0;
            addressed_d = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ADDR, ST_RX_BYTE: if (scl_rise) begin
                    shift_d = {shift_q[6:0], sda_lvl};
                    cnt_d   = cnt_q - 3'd1;
                    if (cnt_q == 3'd0)
                        state_d = (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_RX_ACK;
                end
                // ack_slot distinguishes the fall that opens the ACK bit from the one closing it.
                ST_ADDR_ACK: if (scl_fall) begin
                    if (!ack_slot_q) begin
                        if (shift_q[7:1] == SLAVE_ADDR) begin
                            sda_low_d   = 1'b1;
                            addressed_d = 1'b1;
                            ack_slot_d  = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        ack_slot_d = 1'b0;
                        cnt_d      = 3'd7;
                        if (shift_q[0]) begin
                            state_d   = ST_TX_BYTE;
                            tx_d      = usr.data_in;
                            tx_load_d = 1'b1;
                            sda_low_d = ~usr.data_in[7];
                        end else begin
                            state_d   = ST_RX_BYTE;
                            sda_low_d = 1'b0;
                        end
                    end
                end
                ST_RX_ACK: if (scl_fall) begin
                    if (!ack_slot_q) begin
                        data_out_d = shift_q;
                        rx_valid_d = 1'b1;
                        sda_low_d  = (usr.rx_nack != NACK);
                        ack_slot_d = 1'b1;
                    end else begin
                        sda_low_d  = 1'b0;
                        ack_slot_d = 1'b0;
                        cnt_d      = 3'd7;
                        state_d    = ST_RX_BYTE;
                    end
                end
                ST_TX_BYTE: if (scl_fall) begin
                    if (cnt_q == 3'd0) begin
                        sda_low_d = 1'b0;
                        cnt_d     = 3'd7;
                        state_d   = ST_TX_ACK;
                    end else begin
                        tx_d      = {tx_q[6:0], 1'b0};
                        sda_low_d = ~tx_q[6];
                        cnt_d     = cnt_q - 3'd1;
                    end
                end
                ST_TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_lvl == ACK) begin
                            ack_slot_d = 1'b1;
                        end else begin
                            mnack_d     = 1'b1;
                            addressed_d = 1'b0;
                            state_d     = ST_IDLE;
                        end
                    end else if (scl_fall && ack_slot_q) begin
                        ack_slot_d = 1'b0;
                        state_d    = ST_TX_BYTE;
                        tx_d       = usr.data_in;
                        tx_load_d  = 1'b1;
                        sda_low_d  = ~usr.data_in[7];
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign i2c_sda                  = sda_low_q ? 1'b0 : 1'bz;
    assign usr.data_out             = data_out_q;
    assign usr.rx_valid             = rx_valid_q;
    assign usr.tx_load              = tx_load_q;
    assign usr.master_nack_received = mnack_q;
    assign usr.addressed            = addressed_q;
    assign usr.bus_busy             = busy_q;
    assign usr.i2c_state            = state_q;

endmodule

// File: tb/tb_i2c_slave_controller.sv
// tb/tb_i2c_slave_controller.sv - bus-master stimulus with scoreboarded receive/transmit bytes
module tb_i2c_slave_controller;

    localparam int Q = 6;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic scl = 1'b1;
    logic m_sda_low = 1'b0;
    wire  i2c_sda;

    always #5 clk = ~clk;

    assign i2c_sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (i2c_sda);
    wire sda_bus = (i2c_sda !== 1'b0);

    i2c_slave_controller_if usr_if ();

    i2c_slave_controller #(.SLAVE_ADDR(7'h42), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .i2c_sda(i2c_sda), .i2c_scl(scl), .usr(usr_if.slave)
    );

    int n_checks = 0;
    int n_fail = 0;
    int rx_cnt = 0, tx_load_cnt = 0, mnack_cnt = 0;
    logic [7:0] rx_exp[$];
    logic [7:0] tx_exp[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic wait_q(input int n);
        repeat (n * Q) @(negedge clk);
    endtask

    // Scoreboard side: every rx_valid pulse must match the next pushed write byte.
    always @(negedge clk) begin
        if (reset) begin
            if (usr_if.rx_valid) begin
                rx_cnt++;
                if (rx_exp.size() == 0) check("rx_unexpected", {24'h0, usr_if.data_out}, 32'hFFFF_FFFF);
                else check("rx_data", {24'h0, usr_if.data_out}, {24'h0, rx_exp.pop_front()});
            end
            if (usr_if.tx_load) tx_load_cnt++;
            if (usr_if.master_nack_received) mnack_cnt++;
        end
    end

    task automatic bus_start();
        m_sda_low = 1'b1; wait_q(2);
        scl = 1'b0;       wait_q(1);
    endtask

    task automatic bus_rep_start();
        m_sda_low = 1'b0; wait_q(1);
        scl = 1'b1;       wait_q(1);
        m_sda_low = 1'b1; wait_q(1);
        scl = 1'b0;       wait_q(1);
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1; wait_q(1);
        scl = 1'b1;       wait_q(1);
        m_sda_low = 1'b0; wait_q(2);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda_low = ~b[i]; wait_q(1);
            scl = 1'b1;        wait_q(2);
            scl = 1'b0;        wait_q(1);
        end
        m_sda_low = 1'b0; wait_q(1);
        scl = 1'b1;       wait_q(1);
        ack = sda_bus;    wait_q(1);
        scl = 1'b0;       wait_q(1);
    endtask

    task automatic read_byte(input logic master_nack, output logic [7:0] b);
        m_sda_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            wait_q(1);
            scl = 1'b1;   wait_q(1);
            b[i] = sda_bus; wait_q(1);
            scl = 1'b0;   wait_q(1);
        end
        m_sda_low = ~master_nack; wait_q(1);
        scl = 1'b1;       wait_q(2);
        scl = 1'b0;       wait_q(1);
        m_sda_low = 1'b0;
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] b0;
        logic [7:0] b1;
        logic       rx_nack;
        logic       exp_match;
    } wvec_t;

    wvec_t vecs[4];

    initial begin
        logic a;
        logic [7:0] rb;
        int rx0, tl0, mn0;

        vecs[0] = '{8'h84, 8'hA5, 8'h5A, 1'b0, 1'b1};
        vecs[1] = '{8'h86, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{8'h84, 8'h99, 8'h3C, 1'b1, 1'b1};
        vecs[3] = '{8'h00, 8'h12, 8'h34, 1'b0, 1'b0};

        usr_if.data_in = 8'h00;
        usr_if.rx_nack = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        check("reset_state", {29'h0, usr_if.i2c_state}, 32'h0);
        check("reset_outs", {usr_if.data_out, usr_if.rx_valid, usr_if.tx_load,
              usr_if.master_nack_received, usr_if.addressed, usr_if.bus_busy}, 32'h0);
        check("reset_sda", {31'h0, sda_bus}, 32'h1);

        foreach (vecs[k]) begin
            usr_if.rx_nack = vecs[k].rx_nack;
            rx0 = rx_cnt;
            bus_start();
            check("busy_after_start", {31'h0, usr_if.bus_busy}, 32'h1);
            write_byte(vecs[k].addr, a);
            check("addr_ack", {31'h0, a}, {31'h0, ~vecs[k].exp_match});
            check("addressed", {31'h0, usr_if.addressed}, {31'h0, vecs[k].exp_match});
            if (!vecs[k].exp_match)
                check("idle_after_mismatch", {29'h0, usr_if.i2c_state}, 32'h0);
            if (vecs[k].exp_match) rx_exp.push_back(vecs[k].b0);
            write_byte(vecs[k].b0, a);
            check("data0_ack", {31'h0, a}, {31'h0, ~(vecs[k].exp_match & ~vecs[k].rx_nack)});
            if (vecs[k].exp_match) rx_exp.push_back(vecs[k].b1);
            write_byte(vecs[k].b1, a);
            check("data1_ack", {31'h0, a}, {31'h0, ~(vecs[k].exp_match & ~vecs[k].rx_nack)});
            bus_stop();
            check("busy_after_stop", {31'h0, usr_if.bus_busy}, 32'h0);
            check("addressed_after_stop", {31'h0, usr_if.addressed}, 32'h0);
            check("rx_count", rx_cnt - rx0, vecs[k].exp_match ? 32'd2 : 32'd0);
            if (vecs[k].exp_match)
                check("data_out_last", {24'h0, usr_if.data_out}, {24'h0, vecs[k].b1});
        end
        usr_if.rx_nack = 1'b0;

        // Read: two bytes, master ACKs the first and NACKs the second.
        tl0 = tx_load_cnt; mn0 = mnack_cnt;
        usr_if.data_in = 8'h3C; tx_exp.push_back(8'h3C);
        bus_start();
        write_byte(8'h85, a);
        check("rd_addr_ack", {31'h0, a}, 32'h0);
        usr_if.data_in = 8'hC3; tx_exp.push_back(8'hC3);
        read_byte(1'b0, rb);
        check("rd_byte0", {24'h0, rb}, {24'h0, tx_exp.pop_front()});
        read_byte(1'b1, rb);
        check("rd_byte1", {24'h0, rb}, {24'h0, tx_exp.pop_front()});
        check("rd_sda_released", {31'h0, sda_bus}, 32'h1);
        check("rd_idle", {29'h0, usr_if.i2c_state}, 32'h0);
        check("rd_addressed_cleared", {31'h0, usr_if.addressed}, 32'h0);
        bus_stop();
        check("rd_tx_loads", tx_load_cnt - tl0, 32'd2);
        check("rd_mnack", mnack_cnt - mn0, 32'd1);

        // Repeated START from a write into a read.
        rx0 = rx_cnt; mn0 = mnack_cnt;
        bus_start();
        write_byte(8'h84, a);
        check("rs_addr_ack", {31'h0, a}, 32'h0);
        rx_exp.push_back(8'h10);
        write_byte(8'h10, a);
        check("rs_data_ack", {31'h0, a}, 32'h0);
        check("rs_addressed_before", {31'h0, usr_if.addressed}, 32'h1);
        usr_if.data_in = 8'h77; tx_exp.push_back(8'h77);
        bus_rep_start();
        check("rs_addressed_drop", {31'h0, usr_if.addressed}, 32'h0);
        check("rs_state_addr", {29'h0, usr_if.i2c_state}, 32'h1);
        write_byte(8'h85, a);
        check("rs_addr2_ack", {31'h0, a}, 32'h0);
        check("rs_addressed_rise", {31'h0, usr_if.addressed}, 32'h1);
        read_byte(1'b1, rb);
        check("rs_tx_byte", {24'h0, rb}, {24'h0, tx_exp.pop_front()});
        bus_stop();
        check("rs_data_out", {24'h0, usr_if.data_out}, 32'h10);
        check("rs_rx_count", rx_cnt - rx0, 32'd1);
        check("rs_mnack", mnack_cnt - mn0, 32'd1);

        // Reset while the target drives a 0 data bit.
        usr_if.data_in = 8'h00;
        bus_start();
        write_byte(8'h85, a);
        check("rst_addr_ack", {31'h0, a}, 32'h0);
        check("rst_driving_low", {31'h0, sda_bus}, 32'h0);
        reset = 1'b0;
        #1;
        check("rst_sda_released", {31'h0, sda_bus}, 32'h1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_state", {29'h0, usr_if.i2c_state}, 32'h0);
        check("rst_outs", {usr_if.data_out, usr_if.rx_valid, usr_if.tx_load,
              usr_if.master_nack_received, usr_if.addressed, usr_if.bus_busy}, 32'h0);
        scl = 1'b1; wait_q(1);
        bus_stop();

        check("rx_queue_drained", rx_exp.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/i2c_slave_controller.md
Name: i2c_slave_controller

Overview:
- 7-bit-address I2C target (slave) that answers the team's i2c_controller master on the same open-drain bus.
- Oversamples SDA/SCL on the system clock, detects START/STOP, matches its own address, ACKs, receives write bytes, and serves read bytes from a user-side byte interface.
- No clock stretching; SCL is input-only.

Parameters:
- SLAVE_ADDR, 7'h42, own 7-bit bus address.
- SYNC_STAGES, 2, synchronizer flops per bus line (minimum 2).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- i2c_sda  inout  1  open-drain data; driven 0 or released (z), never driven 1.
- i2c_scl  input  1  bus clock from master.
- data_in  input  8  byte to transmit; sampled on the tx_load cycle.
- rx_nack  input  1  when 1 at the 8th received data bit, respond NACK instead of ACK.
- data_out  output  8  last received write byte.
- rx_valid  output  1  1-cycle pulse: data_out updated.
- tx_load  output  1  1-cycle pulse: data_in captured for transmission.
- master_nack_received  output  1  1-cycle pulse: master NACKed a read byte.
- addressed  output  1  high from own-address ACK until STOP, repeated START, or master NACK.
- bus_busy  output  1  high between any START and STOP.
- i2c_state  output  3  current FSM state (debug).

Behaviour:
- Reset (reset==0, asynchronous): SDA released, state IDLE, all outputs 0, synchronizers preset to 1. Release is immediate even mid-transfer.
- Line conditioning: SYNC_STAGES flops plus one history flop per line. Edges are detected SYNC_STAGES+1 clk after the pin changes. All decisions use the synchronized values only.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are checked before any state logic and win in every state.
- START (including repeated): go to ADDR, bit counter = 7, SDA released, addressed cleared, bus_busy = 1.
- STOP: go to IDLE, SDA released, bus_busy = 0, addressed = 0.
- States:
  - IDLE 000: wait for START.
  - ADDR 001: shift SDA in on each SCL rise, MSB first, 8 bits.
  - ADDR_ACK 010: after the 8th SCL fall, if shift[7:1]==SLAVE_ADDR, drive SDA low and set addressed; otherwise release SDA and return to IDLE until the next START. General call (0x00) is not acknowledged.
  - RX_BYTE 011: on the SCL fall ending the ACK, release SDA; shift in 8 bits on SCL rises.
  - RX_ACK 100: on the 8th SCL fall, data_out <= shift and rx_valid pulses; drive SDA low unless rx_nack==1. On the next SCL fall, release SDA and return to RX_BYTE.
  - TX_BYTE 101: entered on the SCL fall ending the address ACK (R/W=1) or a master ACK. That cycle: tx_load pulses, data_in is captured, and SDA drives bit 7. Each subsequent SCL fall presents the next bit; bit=1 means released.
  - TX_ACK 110: after the 8th bit's SCL fall, release SDA and sample SDA on the next SCL rise. 0 returns to TX_BYTE on the following fall. 1 pulses master_nack_received, clears addressed, and goes to IDLE with SDA released; only STOP or START follows.
- SDA changes only on detected SCL falls, which gives at least SYNC_STAGES+1 clk of hold after the pin edge.
- Bit counter is 3 bits and wraps 0->7 at each byte boundary.
- Simultaneous START/STOP detection with a data edge: the bus condition wins.

Decomposition:
- Package i2c_pkg: state encodings (3'b000..3'b110), ACK=1'b0, NACK=1'b1.
- Sub-module i2c_line_sync: N-stage synchronizer plus rise/fall detect, instantiated once for SDA and once for SCL.

Test Plan:
- Write: START, 0x84, 0xA5, 0x5A, STOP -> SDA low on all 3 ACK bits; rx_valid pulses twice; data_out = 0xA5 then 0x5A; bus_busy 1->0 at STOP.
- Read: START, 0x85, data_in = 0x3C, master ACK, data_in = 0xC3, master NACK, STOP -> tx_load twice; SDA bits 00111100 then 11000011; one master_nack_received pulse; SDA released afterwards.
- Address mismatch: START, 0x86, 0xFF, STOP -> SDA never driven low; rx_valid never pulses; state stays IDLE after the ACK slot.
- Repeated START: START, 0x84, 0x10, START, 0x85, read 0x77, NACK, STOP -> data_out = 0x10; addressed drops at the repeated START and rises at the second ACK; 0x77 transmitted.
- rx_nack: write 0x84 then 0x99 with rx_nack = 1 -> address ACKed; data byte NACKed (SDA released); data_out = 0x99.
- Reset mid-TX while driving bit = 0 -> SDA released in the same cycle reset falls; after reset release, all outputs 0 and state IDLE.
